// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester byte/halfword RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef logic req_idx_t;

  localparam logic [15:0] RAM_TOP = 16'h4000;

  // First byte address of a RAM of 2^addrbits bytes that ends just below RAM_TOP.
  function automatic logic [15:0] ram_base(input int addrbits);
    logic [31:0] size;
    size = 32'd1 << addrbits;
    return RAM_TOP - size[15:0];
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter.
// Handshake: the master raises req with addr/we/wide/wdata stable and holds it until
// ack pulses for one cycle; err and rdata are valid in that cycle, then req must drop.
interface ram_arbiter_if;
  logic        req;
  logic [14:0] addr;
  logic        we;
  logic        wide;
  logic [15:0] wdata;
  logic        ack;
  logic        err;
  logic [15:0] rdata;

  modport master (output req, addr, we, wide, wdata, input ack, err, rdata);
  modport slave  (input req, addr, we, wide, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_lane_map.sv
// Combinational mapping of one byte/halfword access onto the even/odd byte banks,
// including window check, write steering and big-endian read reassembly.
module ram_lane_map
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRBITS = 10
) (
  input  logic [14:0] addr_i,
  input  logic        wide_i,
  input  logic        we_i,
  input  logic [15:0] wdata_i,
  input  logic [7:0]  rd_even_i,
  input  logic [7:0]  rd_odd_i,
  output logic        valid_o,
  output logic [14:0] addr_even_o,
  output logic [14:0] addr_odd_o,
  output logic [7:0]  wd_even_o,
  output logic [7:0]  wd_odd_o,
  output logic        we_even_o,
  output logic        we_odd_o,
  output logic [15:0] rdata_o
);

  localparam logic [15:0] RAM_BASE = ram_base(ADDRBITS);

  logic [15:0] first16;
  logic [15:0] last16;
  logic [14:0] addr_next;
  logic        odd;

  always_comb begin
    // 16-bit compare so a wide access at the last byte cannot wrap into range.
    first16   = {1'b0, addr_i};
    last16    = first16 + {15'd0, wide_i};
    valid_o   = (first16 >= RAM_BASE) && (last16 < RAM_TOP);
    odd       = addr_i[0];
    addr_next = addr_i + 15'd1;

    // Each bank sees the byte address of the byte it holds; the RAM uses bits [ADDRBITS-1:1].
    addr_even_o = odd ? addr_next : addr_i;
    addr_odd_o  = odd ? addr_i : addr_next;

    wd_even_o = (wide_i && !odd) ? wdata_i[15:8] : wdata_i[7:0];
    wd_odd_o  = (wide_i && odd)  ? wdata_i[15:8] : wdata_i[7:0];
    we_even_o = we_i && valid_o && (wide_i || !odd);
    we_odd_o  = we_i && valid_o && (wide_i || odd);

    if (!wide_i)  rdata_o = {8'h00, odd ? rd_odd_i : rd_even_i};
    else if (odd) rdata_o = {rd_odd_i, rd_even_i};
    else          rdata_o = {rd_even_i, rd_odd_i};
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter granting two requesters access to a two-bank byte RAM,
// one access per IDLE -> ACCESS -> RESP sequence.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRBITS = 10
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic [14:0]   dread_addr_even,
  output logic [14:0]   dread_addr_odd,
  input  logic [7:0]    dread_data_even,
  input  logic [7:0]    dread_data_odd,
  output logic [14:0]   dwrite_addr_even,
  output logic [14:0]   dwrite_addr_odd,
  output logic [7:0]    dwrite_data_even,
  output logic [7:0]    dwrite_data_odd,
  output logic          dwrite_en_even,
  output logic          dwrite_en_odd,
  output state_t        state_o
);

  state_t      state_q, state_d;
  req_idx_t    last_q, last_d, gnt_q, gnt_d;
  logic [14:0] addr_q, addr_d;
  logic        we_q, we_d, wide_q, wide_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        map_valid, map_we_even, map_we_odd;
  logic [14:0] map_addr_even, map_addr_odd;
  logic [7:0]  map_wd_even, map_wd_odd;
  logic [15:0] map_rdata, resp_data;
  logic        in_access;

  ram_lane_map #(.ADDRBITS(ADDRBITS)) u_map (
    .addr_i      (addr_q),
    .wide_i      (wide_q),
    .we_i        (we_q),
    .wdata_i     (wdata_q),
    .rd_even_i   (dread_data_even),
    .rd_odd_i    (dread_data_odd),
    .valid_o     (map_valid),
    .addr_even_o (map_addr_even),
    .addr_odd_o  (map_addr_odd),
    .wd_even_o   (map_wd_even),
    .wd_odd_o    (map_wd_odd),
    .we_even_o   (map_we_even),
    .we_odd_o    (map_we_odd),
    .rdata_o     (map_rdata)
  );

  assign resp_data = (map_valid && !we_q) ? map_rdata : 16'h0000;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wide_d   = wide_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0.req || m1.req) begin
          // On a tie the requester not served last wins.
          gnt_d   = (m0.req && m1.req) ? ~last_q : m1.req;
          last_d  = gnt_d;
          addr_d  = gnt_d ? m1.addr  : m0.addr;
          we_d    = gnt_d ? m1.we    : m0.we;
          wide_d  = gnt_d ? m1.wide  : m0.wide;
          wdata_d = gnt_d ? m1.wdata : m0.wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        err_d[gnt_q] = ~map_valid;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (gnt_q) rdata1_d = resp_data;
        else       rdata0_d = resp_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wide_q   <= 1'b0;
      wdata_q  <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wide_q   <= wide_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // RAM ports are only driven during ACCESS; the read data arrives in RESP.
  assign in_access        = (state_q == ST_ACCESS);
  assign dread_addr_even  = in_access ? map_addr_even : 15'd0;
  assign dread_addr_odd   = in_access ? map_addr_odd  : 15'd0;
  assign dwrite_addr_even = in_access ? map_addr_even : 15'd0;
  assign dwrite_addr_odd  = in_access ? map_addr_odd  : 15'd0;
  assign dwrite_data_even = in_access ? map_wd_even   : 8'd0;
  assign dwrite_data_odd  = in_access ? map_wd_odd    : 8'd0;
  assign dwrite_en_even   = in_access && map_we_even;
  assign dwrite_en_odd    = in_access && map_we_odd;

  assign m0.ack   = (state_q == ST_RESP) && (gnt_q == 1'b0);
  assign m1.ack   = (state_q == ST_RESP) && (gnt_q == 1'b1);
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = m0.ack ? resp_data : rdata0_q;
  assign m1.rdata = m1.ack ? resp_data : rdata1_q;
  assign state_o  = state_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDRBITS, default 10, RAM size 2^ADDRBITS bytes; window RAMBASE = 0x4000 - 2^ADDRBITS up to 0x3fff.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 mN_req  in  1  requester N (N=0,1) access request, held until ack.
REQ-005 mN_addr  in  15  byte address, stable while req.
REQ-006 mN_we  in  1  1=write, 0=read.
REQ-007 mN_wide  in  1  1=16-bit access (bytes A, A+1), 0=byte at A.
REQ-008 mN_wdata  in  16  write data; byte access uses [7:0]; wide: [15:8] to A, [7:0] to A+1 (big-endian).
REQ-009 mN_ack  out  1  one-cycle completion pulse.
REQ-010 mN_err  out  1  valid with ack; out-of-window access.
REQ-011 mN_rdata  out  16  read data valid with ack, same byte order as wdata; byte read in [7:0], [15:8]=0.
REQ-012 dread_addr_even/odd  out  15, dread_data_even/odd  in  8  RAM bank read ports, synchronous read, 1-cycle latency.
REQ-013 dwrite_addr_even/odd  out  15, dwrite_data_even/odd  out  8, dwrite_en_even/odd  out  1  RAM bank write ports.

Function
REQ-014 States IDLE, ACCESS, RESP; IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always; throughput one access per 3 cycles.
REQ-015 In IDLE with both reqs high, grant the requester not granted last; single req granted directly; grant latched at IDLE->ACCESS.
REQ-016 After reset the last-granted pointer is 1 so m0 wins the first tie.
REQ-017 Bank select = address bit 0 (0=even, 1=odd); bank word index = address bits [ADDRBITS-1:1]; ADDR bits driven unmodified.
REQ-018 Wide access at even A: high byte even bank, low byte odd bank, same index; at odd A: high byte odd bank index k, low byte even bank index k+1.
REQ-019 Valid iff A >= RAMBASE and (A + wide) <= 0x3fff, computed 16 bits wide so 0x3fff wide is invalid (no wrap).
REQ-020 In ACCESS, a valid write asserts dwrite_en only on touched bank(s) for exactly that cycle; invalid or read access asserts no write enable.
REQ-021 In ACCESS, read addresses drive the granted request; in RESP rdata is assembled from dread_data and registered.
REQ-022 In RESP, granted ack pulses one cycle; err=1 and rdata=0 for invalid; err=0 otherwise; other requester's ack stays 0.
REQ-023 rdata/err hold last values between acks; outside ACCESS all write enables 0.
REQ-024 req dropped before ack is a protocol error; the access still completes and acks.
REQ-025 Req still high in the RESP cycle is not re-granted until IDLE is seen (requester must drop req after ack).

Reset
REQ-026 Reset forces IDLE, pointer=1, all ack/err/dwrite_en=0, rdata=0, all RAM addresses/data=0.
REQ-027 Reset during ACCESS or RESP aborts with no ack; a write enable already sampled by RAM is not undone.

Structure
REQ-028 Package ram_arbiter_pkg holds state enum, RAM_TOP=16'h4000 constant, requester index type.
REQ-029 Sub-module ram_lane_map: combinational address/width/we -> per-bank index, enables, data steering and read reassembly.

Verification
REQ-030 ADDRBITS=10: m0 wide write 0x3c00 data 0xA55A -> even[0]=0xA5, odd[0]=0x5A, one ack, err=0.
REQ-031 m1 wide write 0x3c01 data 0x1234 then wide read 0x3c01 -> odd[0]=0x12, even[1]=0x34, rdata 0x1234, 3 cycles each.
REQ-032 Both req same cycle from reset, held -> m0 acked first, m1 next, then alternation m0,m1,m0.
REQ-033 Read 0x3bff, wide write 0x3fff -> err=1, rdata=0, no dwrite_en asserted.
REQ-034 Reset asserted in ACCESS of a read -> no ack, state IDLE, outputs zero; next request completes normally.
REQ-035 Byte write 0x3fff value 0x7E then byte read -> odd bank top index written, rdata=0x007E.
